// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states, prices and coin values.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    RETURN
  } state_t;

  localparam int PRICE2    = 2;
  localparam int PRICE6    = 6;
  localparam int COIN1_VAL = 1;
  localparam int COIN5_VAL = 5;

endpackage

// File: rtl/edge_det.sv
// Single-bit rising-edge detector; the history bit clears on reset so a level
// already high when reset releases is reported as an edge.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: tracks coin credit, dispenses 2/6-unit items on request
// edges and refunds credit as a train of 1-unit coin pulses.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin1,
  input  logic                coin5,
  input  logic                get2,
  input  logic                get6,
  input  logic                backAll,
  output logic [CREDIT_W-1:0] credit,
  output logic                out2,
  output logic                out6,
  output logic                coin_out,
  output logic                coin_rej,
  output logic                err_short,
  output logic                busy
);

  localparam int SW = CREDIT_W + 1;
  typedef logic [SW-1:0] wide_t;

  // One spare bit so credit + coin cannot wrap before the ceiling test.
  function automatic logic within_ceiling(input wide_t v);
    return v <= wide_t'(MAX_CREDIT);
  endfunction

  logic rise2, rise6, rise_b;

  edge_det u_edge_get2 (.clk(clk), .rst(rst), .level(get2),    .rise(rise2));
  edge_det u_edge_get6 (.clk(clk), .rst(rst), .level(get6),    .rise(rise6));
  edge_det u_edge_back (.clk(clk), .rst(rst), .level(backAll), .rise(rise_b));

  state_t              state, state_nxt;
  logic                phase, phase_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                out2_nxt, out6_nxt, coin_out_nxt, coin_rej_nxt, err_short_nxt, busy_nxt;
  wide_t               coin_val, base;

  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    credit_nxt    = credit;
    out2_nxt      = 1'b0;
    out6_nxt      = 1'b0;
    coin_out_nxt  = 1'b0;
    coin_rej_nxt  = 1'b0;
    err_short_nxt = 1'b0;
    coin_val      = '0;
    base          = {1'b0, credit};

    if (coin1) coin_val = coin_val + wide_t'(COIN1_VAL);
    if (coin5) coin_val = coin_val + wide_t'(COIN5_VAL);

    case (state)
      IDLE: begin
        // backAll wins; a coinciding purchase edge is dropped.
        if (!rise_b) begin
          if (rise6) begin
            if (credit >= CREDIT_W'(PRICE6)) begin
              base      = base - wide_t'(PRICE6);
              state_nxt = VEND;
              out6_nxt  = 1'b1;
            end else begin
              err_short_nxt = 1'b1;
            end
          end else if (rise2) begin
            if (credit >= CREDIT_W'(PRICE2)) begin
              base      = base - wide_t'(PRICE2);
              state_nxt = VEND;
              out2_nxt  = 1'b1;
            end else begin
              err_short_nxt = 1'b1;
            end
          end
        end
      end
      VEND: begin
        state_nxt = IDLE;
      end
      RETURN: begin
        if (coin_val != '0) coin_rej_nxt = 1'b1;
        // phase high marks the gap cycle that follows each refund pulse.
        if (phase) begin
          phase_nxt = 1'b0;
        end else if (credit == '0) begin
          state_nxt = IDLE;
        end else begin
          coin_out_nxt = 1'b1;
          credit_nxt   = credit - CREDIT_W'(1);
          phase_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (state != RETURN) begin
      if (coin_val != '0) begin
        if (within_ceiling(base + coin_val)) begin
          base = base + coin_val;
        end else begin
          coin_rej_nxt = 1'b1;
        end
      end
      // The first refund pulse is issued on entry, so the decrement happens here.
      if (state == IDLE && rise_b && credit != '0) begin
        state_nxt    = RETURN;
        coin_out_nxt = 1'b1;
        phase_nxt    = 1'b1;
        base         = base - wide_t'(1);
      end
      credit_nxt = base[CREDIT_W-1:0];
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      credit    <= '0;
      out2      <= 1'b0;
      out6      <= 1'b0;
      coin_out  <= 1'b0;
      coin_rej  <= 1'b0;
      err_short <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      credit    <= credit_nxt;
      out2      <= out2_nxt;
      out6      <= out6_nxt;
      coin_out  <= coin_out_nxt;
      coin_rej  <= coin_rej_nxt;
      err_short <= err_short_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: a transaction-level model predicts each
// cycle's outputs into a queue that a separate monitor drains and compares.
module tb_vend_ctrl;

  localparam int CW  = 5;
  localparam int MAX = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          coin1 = 1'b0, coin5 = 1'b0, get2 = 1'b0, get6 = 1'b0, backAll = 1'b0;
  logic [CW-1:0] credit;
  logic          out2, out6, coin_out, coin_rej, err_short, busy;

  vend_ctrl #(.CREDIT_W(CW), .MAX_CREDIT(MAX)) dut (
    .clk(clk), .rst(rst), .coin1(coin1), .coin5(coin5), .get2(get2), .get6(get6),
    .backAll(backAll), .credit(credit), .out2(out2), .out6(out6), .coin_out(coin_out),
    .coin_rej(coin_rej), .err_short(err_short), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int credit;
    bit o2, o6, co, rej, err, busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: credit, one pending dispense cycle, refund progress.
  int m_credit = 0;
  bit m_vend = 0;
  int m_total = 0;
  int m_idx = 0;  // 1..2*m_total while refunding, 0 otherwise
  bit p2 = 0, p6 = 0, pb = 0;

  task automatic model_reset(output exp_t e);
    m_credit = 0; m_vend = 0; m_total = 0; m_idx = 0;
    p2 = 0; p6 = 0; pb = 0;
    e = '{credit: 0, o2: 0, o6: 0, co: 0, rej: 0, err: 0, busy: 0};
  endtask

  task automatic model_step(input bit c1, input bit c5, input bit g2, input bit g6,
                            input bit ba, output exp_t e);
    bit r2, r6, rb, idle;
    int coin, c;
    r2 = g2 && !p2; r6 = g6 && !p6; rb = ba && !pb;
    p2 = g2; p6 = g6; pb = ba;
    coin = int'(c1) + 5 * int'(c5);
    e = '{credit: 0, o2: 0, o6: 0, co: 0, rej: 0, err: 0, busy: 0};
    if (m_idx > 0) begin
      e.rej = (coin > 0);
      if (m_idx == 2 * m_total) begin
        m_idx = 0; m_credit = 0;
      end else begin
        m_idx++;
        e.co = (m_idx % 2 == 1);
        m_credit = m_total - (m_idx + 1) / 2;
        e.busy = 1;
      end
      e.credit = m_credit;
    end else begin
      idle = !m_vend;
      m_vend = 0;
      c = m_credit;
      if (idle && !rb) begin
        if (r6) begin
          if (c >= 6) begin c -= 6; e.o6 = 1; end else e.err = 1;
        end else if (r2) begin
          if (c >= 2) begin c -= 2; e.o2 = 1; end else e.err = 1;
        end
      end
      if (coin > 0) begin
        if (c + coin > MAX) e.rej = 1; else c += coin;
      end
      if (idle && rb && m_credit > 0) begin
        m_total = c; m_idx = 1;
        e.co = 1; e.busy = 1;
        m_credit = c - 1;
      end else begin
        m_credit = c;
        if (e.o2 || e.o6) begin m_vend = 1; e.busy = 1; end
      end
      e.credit = m_credit;
    end
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples at +1.
  task automatic step(input bit c1, input bit c5, input bit g2, input bit g6, input bit ba);
    exp_t e;
    rst = 1'b0;
    coin1 = c1; coin5 = c5; get2 = g2; get6 = g6; backAll = ba;
    model_step(c1, c5, g2, g6, ba, e);
    exp_q.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic idle_steps(input int n, input bit g2, input bit g6, input bit ba);
    for (int i = 0; i < n; i++) step(0, 0, g2, g6, ba);
  endtask

  task automatic reset_cycle(input bit g2, input bit g6, input bit ba);
    exp_t e;
    rst = 1'b1;
    coin1 = 0; coin5 = 0; get2 = g2; get6 = g6; backAll = ba;
    model_reset(e);
    exp_q.push_back(e);
    #1;
    n_cmp++;
    if (credit !== '0 || coin_out !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: credit=%0d coin_out=%b busy=%b, required 0/0/0",
               credit, coin_out, busy);
    end
    @(posedge clk); #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (int'(credit) != e.credit || out2 !== e.o2 || out6 !== e.o6 ||
            coin_out !== e.co || coin_rej !== e.rej || err_short !== e.err || busy !== e.busy) begin
          n_bad++;
          $display("FAIL outputs @%0t: got credit=%0d o2=%b o6=%b co=%b rej=%b err=%b busy=%b, required credit=%0d o2=%b o6=%b co=%b rej=%b err=%b busy=%b",
                   $time, credit, out2, out6, coin_out, coin_rej, err_short, busy,
                   e.credit, e.o2, e.o6, e.co, e.rej, e.err, e.busy);
        end
      end
    end
  end

  initial begin : driver
    bit lv2, lv6, lvb;
    @(posedge clk); #2;
    reset_cycle(0, 0, 0);
    reset_cycle(0, 0, 0);

    // Basic purchase, held request yields one dispense
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle_steps(4, 0, 1, 0);
    idle_steps(2, 0, 0, 0);

    // Insufficient credit
    reset_cycle(0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle_steps(3, 0, 0, 0);

    // Ceiling, then purchase plus coin in one cycle
    reset_cycle(0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    idle_steps(3, 0, 0, 0);

    // Refund of 3 with a coin inserted mid-refund
    reset_cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    idle_steps(6, 0, 0, 0);

    // Priority: all three requests rise together with credit 8
    reset_cycle(0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    idle_steps(20, 1, 1, 1);
    idle_steps(2, 0, 0, 0);

    // Reset part-way through a refund of 5
    reset_cycle(0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    idle_steps(3, 0, 0, 0);
    reset_cycle(0, 0, 0);
    idle_steps(6, 0, 0, 0);

    // Level high across reset release counts as an edge
    reset_cycle(0, 0, 0);
    step(0, 1, 0, 0, 0);
    reset_cycle(0, 0, 1);
    step(0, 1, 0, 0, 1);
    idle_steps(3, 0, 0, 0);

    // Randomised traffic
    lv2 = 0; lv6 = 0; lvb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_cycle(lv2, lv6, lvb);
      end else begin
        if ($urandom_range(0, 5) == 0) lv2 = !lv2;
        if ($urandom_range(0, 5) == 0) lv6 = !lv6;
        if ($urandom_range(0, 15) == 0) lvb = !lvb;
        step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, lv2, lv6, lvb);
      end
    end
    idle_steps(2, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
